ln_stage1_ctrl: RTL and testbench
=================================

# ln_stage1_ctrl

Sequencer and bank allocator in front of `ln_stage1_accumulate`. It accepts a token as 12 beats of 64×16-bit lanes (768 elements) over a valid/ready handshake and assigns the token a free statistics bank. It drives the accumulator's valid/ptr/cycle-count inputs, then folds the 12 returned partial sums into one per-token sum and one sum-of-squares. The resulting totals go to the LayerNorm mean/variance stage; that stage releases the bank when it has finished with it.

## Interface
- `NUM_BANKS`, 4: statistics banks; pointer width is clog2 (2).
- `BEATS`, 12: beats per token.
- `DATA_W`, 1024: beat width (64 lanes × 16 bit).
- `i_clk`  in  1  clock; all logic is rising-edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_enable`  in  1  global enable, forwarded registered to `o_acc_en`.
- `i_s_valid`  in  1  upstream beat valid.
- `o_s_ready`  out  1  upstream beat ready.
- `i_s_data`  in  DATA_W  upstream beat.
- `o_acc_en`, `o_acc_valid`  out  1  accumulator enable and valid.
- `o_acc_data_flat`  out  DATA_W  registered beat.
- `o_acc_ptr`  out  2  bank pointer. `o_acc_cnt`  out  4  beat index 0..11.
- `i_part_valid`  in  1  accumulator result valid. `i_part_ptr`  in  2. `i_part_cnt`  in  4.
- `i_part_sum`  in  22 signed. `i_part_sq_sum`  in  38 signed.
- `o_res_valid`  out  1  one-cycle pulse: token totals ready.
- `o_res_ptr`  out  2  bank of the completed token.
- `o_res_sum`  out  26 signed. `o_res_sq_sum`  out  42 signed.
- `i_bank_free`  in  1  pulse: downstream releases a bank. `i_bank_free_ptr`  in  2  bank being released.
- `o_busy_mask`  out  NUM_BANKS  banks currently allocated.
- `o_err`  out  2  sticky errors: [0] sequence mismatch, [1] free of a bank not allocated.

## Operation
- Input FSM, two states: IDLE and STREAM.
  - IDLE: `o_s_ready` = (any bank free) & `i_enable`.
  - On handshake in IDLE: allocate the lowest-index free bank, set its busy bit, beat index = 0, go to STREAM.
  - STREAM: `o_s_ready` = `i_enable`.
  - Each handshake forwards the beat with the current index.
  - The handshake with index 11 returns the FSM to IDLE.
- Gaps inside a token (`i_s_valid` low) are legal. The accumulator sees `o_acc_valid`=0 on gap cycles; the index and bank are held.
- `i_enable` low stalls the input side only: ready is low and the FSM holds. Result collection continues.
- Collector: the accumulator returns results in order, so a single running sum and square-sum pair is used.
  - `i_part_cnt`=0 loads the pair; other counts add to it.
  - Expected count and pointer are tracked. A mismatch on either sets `o_err[0]`; the value is still summed.
  - On `i_part_cnt`=11, the totals are registered and `o_res_valid` pulses with the bank number.
- Widths: sums are sign-extended, 22→26 and 38→42 bits. No saturation; 12 terms cannot overflow these widths.
- Bank release: `i_bank_free` clears the busy bit of `i_bank_free_ptr`.
  - Release of a bank that is not busy: ignored, and `o_err[1]` is set.
  - Release and allocation in the same cycle: the released bank is not eligible until the next cycle. Allocation uses the pre-release mask.
- Reset: async assert clears all state. Every output resets to 0: valid and ready low, masks, errors, pointers, counts and data all 0. The FSM goes to IDLE.
- A reset mid-token drops that token and frees all banks.

## Timing
- The accumulator-side outputs are registered: an upstream handshake at cycle N gives `o_acc_valid` at N+1.
- `o_s_ready` is combinational from state, busy mask and `i_enable`. It does not depend on `i_s_valid`.
- `o_res_valid` comes one cycle after the `i_part_valid` carrying cnt 11.
- With the accumulator's 7-cycle latency, last-beat handshake to `o_res_valid` is 9 cycles.
- Back-to-back tokens: a new token can start the cycle after beat 11 if a bank is free. Throughput is 1 beat/cycle.
- `o_busy_mask` updates one cycle after the allocating handshake or the `i_bank_free` pulse.

## Structure
- `ln_pkg` holds: the `BEATS`, `LANES`=64 and `LANE_W`=16 constants; the partial and total width constants (22/38/26/42); the `bank_ptr_t` typedef; and the FSM state enum.
- One natural sub-module: `ln_bank_alloc`. It holds the busy mask, priority-encodes the lowest free bank, and handles release and error detection.
- Bench: instantiate with a real `ln_stage1_accumulate` behind it.

## Test plan
- Single token: all lanes equal k on beat k (k = 0..11), then bank 0 is freed.
  - `o_res_ptr`=0, `o_res_sum`=64·66=4224, `o_res_sq_sum`=64·506=32384.
  - `o_res_valid` 9 cycles after the last handshake.
- Five tokens back-to-back with no frees.
  - Banks 0,1,2,3 are allocated in order; ready drops at token 5's first beat.
  - Freeing bank 2 lets token 5 start on bank 2 one cycle later.
- Random `i_s_valid` gaps within a token, all lanes = −3.
  - Sum = −2304, sq = 6912.
  - No `o_acc_valid` during gaps; count continuity holds.
- Release of an idle bank sets `o_err[1]`; mask unchanged. Injecting `i_part_cnt`=5 when 4 is expected sets `o_err[0]`.
- `i_enable` low for 10 cycles mid-token: ready is low, nothing is lost, and the totals still match.
- `i_rst_n` pulse at beat 6: all outputs 0 immediately. The next token is allocated bank 0 and gives correct totals.

Source files
------------

// File: rtl/ln_pkg.sv
// ---------------------------------------------------------------------------
// ln_pkg
// Shared constants and types for the LayerNorm stage-1 control path.
//   BEATS / LANES / LANE_W : token geometry (12 beats of 64 x 16-bit lanes)
//   PSUM_W / PSQ_W         : per-beat partial sum / square-sum widths
//   TSUM_W / TSQ_W         : per-token total widths (12 terms, no overflow)
//   bank_ptr_t             : statistics bank pointer
//   beat_cnt_t             : beat index 0..BEATS-1
//   in_state_e             : input sequencer states
// ---------------------------------------------------------------------------
package ln_pkg;

  localparam int BEATS      = 12;
  localparam int LANES      = 64;
  localparam int LANE_W     = 16;
  localparam int BANK_PTR_W = 2;
  localparam int CNT_W      = 4;

  localparam int PSUM_W = 22;
  localparam int PSQ_W  = 38;
  localparam int TSUM_W = 26;
  localparam int TSQ_W  = 42;

  typedef logic [BANK_PTR_W-1:0] bank_ptr_t;
  typedef logic [CNT_W-1:0]      beat_cnt_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } in_state_e;

endpackage

// File: rtl/ln_bank_alloc.sv
// ---------------------------------------------------------------------------
// ln_bank_alloc
// Tracks which statistics banks are in use and picks the next one to hand out.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_alloc          : allocate o_alloc_ptr this cycle
//   i_free           : release pulse for bank i_free_ptr
//   o_any_free       : at least one bank is idle
//   o_alloc_ptr      : lowest-index idle bank (from the registered mask)
//   o_busy_mask      : registered busy bits
//   o_free_err       : sticky, set when an idle bank is released
// ---------------------------------------------------------------------------
module ln_bank_alloc #(
  parameter int NUM_BANKS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alloc,
  input  logic                  i_free,
  input  ln_pkg::bank_ptr_t     i_free_ptr,
  output logic                  o_any_free,
  output ln_pkg::bank_ptr_t     o_alloc_ptr,
  output logic [NUM_BANKS-1:0]  o_busy_mask,
  output logic                  o_free_err
);
  import ln_pkg::*;

  logic [NUM_BANKS-1:0] busy_q, busy_d;
  logic                 free_err_q;
  bank_ptr_t            alloc_ptr;
  logic                 free_bad;

  // Lowest idle bank wins; scanning downward lets the last hit be the lowest.
  // Both this encoder and the release below work from busy_q, so a bank
  // released this cycle only becomes eligible on the next one.
  always_comb begin
    alloc_ptr = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (!busy_q[b]) alloc_ptr = bank_ptr_t'(b);
    end
  end

  assign free_bad = i_free & ~busy_q[i_free_ptr];

  always_comb begin
    busy_d = busy_q;
    if (i_free && busy_q[i_free_ptr]) busy_d[i_free_ptr] = 1'b0;
    if (i_alloc) busy_d[alloc_ptr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      free_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (free_bad) free_err_q <= 1'b1;
    end
  end

  assign o_any_free  = ~&busy_q;
  assign o_alloc_ptr = alloc_ptr;
  assign o_busy_mask = busy_q;
  assign o_free_err  = free_err_q;

endmodule

// File: rtl/ln_stage1_ctrl.sv
// ---------------------------------------------------------------------------
// ln_stage1_ctrl
// Feeds 12-beat tokens into ln_stage1_accumulate on an allocated statistics
// bank and folds the 12 returned partials into per-token sum / square-sum.
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   i_enable                        : input-side enable, registered to o_acc_en
//   i_s_valid/o_s_ready/i_s_data    : upstream beat handshake
//   o_acc_*                         : registered accumulator drive
//   i_part_*                        : accumulator partial results (in order)
//   o_res_*                         : token totals, o_res_valid is a 1-cycle pulse
//   i_bank_free/i_bank_free_ptr     : downstream bank release
//   o_busy_mask                     : allocated banks
//   o_err                           : sticky [0] sequence mismatch, [1] bad release
// ---------------------------------------------------------------------------
module ln_stage1_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BEATS     = ln_pkg::BEATS,
  parameter int DATA_W    = ln_pkg::LANES * ln_pkg::LANE_W
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_enable,
  input  logic                              i_s_valid,
  output logic                              o_s_ready,
  input  logic [DATA_W-1:0]                 i_s_data,
  output logic                              o_acc_en,
  output logic                              o_acc_valid,
  output logic [DATA_W-1:0]                 o_acc_data_flat,
  output ln_pkg::bank_ptr_t                 o_acc_ptr,
  output ln_pkg::beat_cnt_t                 o_acc_cnt,
  input  logic                              i_part_valid,
  input  ln_pkg::bank_ptr_t                 i_part_ptr,
  input  ln_pkg::beat_cnt_t                 i_part_cnt,
  input  logic signed [ln_pkg::PSUM_W-1:0]  i_part_sum,
  input  logic signed [ln_pkg::PSQ_W-1:0]   i_part_sq_sum,
  output logic                              o_res_valid,
  output ln_pkg::bank_ptr_t                 o_res_ptr,
  output logic signed [ln_pkg::TSUM_W-1:0]  o_res_sum,
  output logic signed [ln_pkg::TSQ_W-1:0]   o_res_sq_sum,
  input  logic                              i_bank_free,
  input  ln_pkg::bank_ptr_t                 i_bank_free_ptr,
  output logic [NUM_BANKS-1:0]              o_busy_mask,
  output logic [1:0]                        o_err
);
  import ln_pkg::*;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);
  localparam int        OCNT_W    = $clog2(NUM_BANKS) + 1;
  localparam logic [OCNT_W-1:0] ORD_FULL = OCNT_W'(NUM_BANKS);

  // ---------------- input sequencer ----------------
  in_state_e         state_q;
  beat_cnt_t         beat_q;
  bank_ptr_t         tok_ptr_q;
  logic              ready_arm_q;   // keeps ready low until the first clock after reset
  logic              acc_en_q, acc_valid_q;
  logic [DATA_W-1:0] acc_data_q;
  bank_ptr_t         acc_ptr_q;
  beat_cnt_t         acc_cnt_q;

  logic      any_free, hs, alloc, free_err;
  bank_ptr_t alloc_ptr;

  assign o_s_ready = ready_arm_q & i_enable & ((state_q == ST_STREAM) | any_free);
  assign hs        = i_s_valid & o_s_ready;
  assign alloc     = hs & (state_q == ST_IDLE);

  ln_bank_alloc #(.NUM_BANKS(NUM_BANKS)) u_bank_alloc (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_alloc     (alloc),
    .i_free      (i_bank_free),
    .i_free_ptr  (i_bank_free_ptr),
    .o_any_free  (any_free),
    .o_alloc_ptr (alloc_ptr),
    .o_busy_mask (o_busy_mask),
    .o_free_err  (free_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      tok_ptr_q   <= '0;
      ready_arm_q <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_data_q  <= '0;
      acc_ptr_q   <= '0;
      acc_cnt_q   <= '0;
    end else begin
      ready_arm_q <= 1'b1;
      acc_en_q    <= i_enable;
      acc_valid_q <= hs;
      if (hs) acc_data_q <= i_s_data;
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            tok_ptr_q <= alloc_ptr;
            acc_ptr_q <= alloc_ptr;
            acc_cnt_q <= '0;
            beat_q    <= beat_cnt_t'(1);
            state_q   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            acc_ptr_q <= tok_ptr_q;
            acc_cnt_q <= beat_q;
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_acc_en        = acc_en_q;
  assign o_acc_valid     = acc_valid_q;
  assign o_acc_data_flat = acc_data_q;
  assign o_acc_ptr       = acc_ptr_q;
  assign o_acc_cnt       = acc_cnt_q;

  // ---------------- result collector ----------------
  // Token order is preserved end to end, so allocated banks are queued here
  // and the head entry is the bank the next partials must carry.
  bank_ptr_t          ord_q [NUM_BANKS];
  bank_ptr_t          ord_wr_q, ord_rd_q;
  logic [OCNT_W-1:0]  ord_cnt_q;

  logic signed [TSUM_W-1:0] sum_q, sum_d, part_sum_x, res_sum_q;
  logic signed [TSQ_W-1:0]  sq_q, sq_d, part_sq_x, res_sq_q;
  beat_cnt_t                exp_cnt_q;
  logic                     part_last, seq_bad, ord_push, ord_pop;
  logic                     seq_err_q, res_valid_q;
  bank_ptr_t                res_ptr_q;

  always_comb begin
    part_sum_x = {{(TSUM_W - PSUM_W){i_part_sum[PSUM_W-1]}}, i_part_sum};
    part_sq_x  = {{(TSQ_W - PSQ_W){i_part_sq_sum[PSQ_W-1]}}, i_part_sq_sum};
    part_last  = (i_part_cnt == LAST_BEAT);
    // Count 0 starts a fresh token; any mismatch is flagged but still summed.
    sum_d      = (i_part_cnt == '0) ? part_sum_x : sum_q + part_sum_x;
    sq_d       = (i_part_cnt == '0) ? part_sq_x  : sq_q  + part_sq_x;
    seq_bad    = (i_part_cnt != exp_cnt_q) || (ord_cnt_q == '0) ||
                 (i_part_ptr != ord_q[ord_rd_q]);
    ord_push   = alloc & (ord_cnt_q != ORD_FULL);
    ord_pop    = i_part_valid & part_last & (ord_cnt_q != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) ord_q[i] <= '0;
      ord_wr_q    <= '0;
      ord_rd_q    <= '0;
      ord_cnt_q   <= '0;
      sum_q       <= '0;
      sq_q        <= '0;
      exp_cnt_q   <= '0;
      seq_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_ptr_q   <= '0;
      res_sum_q   <= '0;
      res_sq_q    <= '0;
    end else begin
      if (ord_push) begin
        ord_q[ord_wr_q] <= alloc_ptr;
        ord_wr_q        <= ord_wr_q + 1'b1;
      end
      if (ord_pop) ord_rd_q <= ord_rd_q + 1'b1;
      case ({ord_push, ord_pop})
        2'b10:   ord_cnt_q <= ord_cnt_q + 1'b1;
        2'b01:   ord_cnt_q <= ord_cnt_q - 1'b1;
        default: ord_cnt_q <= ord_cnt_q;
      endcase

      res_valid_q <= i_part_valid & part_last;
      if (i_part_valid) begin
        sum_q <= sum_d;
        sq_q  <= sq_d;
        // Re-sync on whatever count arrived so one glitch flags once per gap.
        exp_cnt_q <= part_last ? '0 : i_part_cnt + 1'b1;
        if (seq_bad) seq_err_q <= 1'b1;
        if (part_last) begin
          res_ptr_q <= i_part_ptr;
          res_sum_q <= sum_d;
          res_sq_q  <= sq_d;
        end
      end
    end
  end

  assign o_res_valid  = res_valid_q;
  assign o_res_ptr    = res_ptr_q;
  assign o_res_sum    = res_sum_q;
  assign o_res_sq_sum = res_sq_q;
  assign o_err        = {free_err, seq_err_q};

endmodule

// File: tb/tb_ln_stage1_ctrl.sv
module tb_ln_stage1_ctrl;

  localparam int DW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, en, s_valid, s_ready;
  logic [DW-1:0]      s_data;
  logic               acc_en, acc_valid;
  logic [DW-1:0]      acc_data;
  logic [1:0]         acc_ptr;
  logic [3:0]         acc_cnt;
  logic               part_valid;
  logic [1:0]         part_ptr;
  logic [3:0]         part_cnt;
  logic signed [21:0] part_sum;
  logic signed [37:0] part_sq;
  logic               res_valid;
  logic [1:0]         res_ptr;
  logic signed [25:0] res_sum;
  logic signed [41:0] res_sq;
  logic               bank_free;
  logic [1:0]         bank_free_ptr;
  logic [3:0]         busy;
  logic [1:0]         err;

  int   tests  = 0;
  int   failed = 0;
  logic inj    = 1'b0;

  ln_stage1_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (en),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .i_s_data        (s_data),
    .o_acc_en        (acc_en),
    .o_acc_valid     (acc_valid),
    .o_acc_data_flat (acc_data),
    .o_acc_ptr       (acc_ptr),
    .o_acc_cnt       (acc_cnt),
    .i_part_valid    (part_valid),
    .i_part_ptr      (part_ptr),
    .i_part_cnt      (part_cnt),
    .i_part_sum      (part_sum),
    .i_part_sq_sum   (part_sq),
    .o_res_valid     (res_valid),
    .o_res_ptr       (res_ptr),
    .o_res_sum       (res_sum),
    .o_res_sq_sum    (res_sq),
    .i_bank_free     (bank_free),
    .i_bank_free_ptr (bank_free_ptr),
    .o_busy_mask     (busy),
    .o_err           (err)
  );

  // Behavioural stand-in for the 7-cycle ln_stage1_accumulate.
  typedef struct packed {
    logic               v;
    logic [1:0]         p;
    logic [3:0]         c;
    logic signed [21:0] s;
    logic signed [37:0] q;
  } part_t;

  part_t pipe [7];

  function automatic logic signed [21:0] lane_sum(input logic [DW-1:0] d);
    logic signed [21:0] a;
    logic signed [15:0] e;
    a = '0;
    for (int l = 0; l < 64; l++) begin
      e = d[l*16 +: 16];
      a = a + e;
    end
    return a;
  endfunction

  function automatic logic signed [37:0] lane_sq(input logic [DW-1:0] d);
    logic signed [37:0] a;
    logic signed [15:0] e;
    a = '0;
    for (int l = 0; l < 64; l++) begin
      e = d[l*16 +: 16];
      a = a + e * e;
    end
    return a;
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] r;
    logic [15:0]   lv;
    lv = 16'(v);
    for (int l = 0; l < 64; l++) r[l*16 +: 16] = lv;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) pipe[i] <= '0;
    end else begin
      pipe[0].v <= acc_en & acc_valid;
      pipe[0].p <= acc_ptr;
      pipe[0].c <= acc_cnt;
      pipe[0].s <= lane_sum(acc_data);
      pipe[0].q <= lane_sq(acc_data);
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign part_valid = pipe[6].v;
  assign part_ptr   = pipe[6].p;
  assign part_cnt   = (inj && pipe[6].c == 4'd4) ? 4'd5 : pipe[6].c;
  assign part_sum   = pipe[6].s;
  assign part_sq    = pipe[6].q;

  // Result monitor.
  typedef struct {
    logic [1:0] p;
    longint     s;
    longint     q;
  } res_t;
  res_t rq[$];

  always @(posedge clk) begin
    if (res_valid) rq.push_back('{res_ptr, longint'(res_sum), longint'(res_sq)});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and returns 1 time unit after the handshaking edge.
  task automatic send(input int v);
    s_data  = fill(v);
    s_valid = 1'b1;
    #1;
    for (int n = 0; n < 64; n++) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        $display("[TB] beat v=%0d ptr=%0d cnt=%0d", v, acc_ptr, acc_cnt);
        return;
      end
      tick();
    end
    s_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic wait_res(input int n);
    for (int c = 0; c < 200 && rq.size() < n; c++) tick();
    chk("result_arrived", longint'(rq.size() >= n), 1);
  endtask

  task automatic chk_res(input string tag, input int idx, input int p, input longint s, input longint q);
    if (rq.size() > idx) begin
      $display("[TB] result %s ptr=%0d sum=%0d sq=%0d", tag, rq[idx].p, rq[idx].s, rq[idx].q);
      chk({tag, "_ptr"}, rq[idx].p, p);
      chk({tag, "_sum"}, rq[idx].s, s);
      chk({tag, "_sq"},  rq[idx].q, q);
    end
  endtask

  task automatic free_bank(input int p);
    bank_free     = 1'b1;
    bank_free_ptr = 2'(p);
    tick();
    bank_free     = 1'b0;
  endtask

  initial begin
    int lat;
    int base;
    int gaps;

    rst_n = 1'b0; en = 1'b1; s_valid = 1'b0; s_data = '0;
    bank_free = 1'b0; bank_free_ptr = '0;

    // ---- reset state ----
    #3;
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("idle_ready", s_ready, 1);

    // ---- single token, lanes = k on beat k ----
    for (int k = 0; k < 12; k++) begin
      send(k);
      chk("t1_cnt", acc_cnt, k);
      if (k == 0) begin
        chk("t1_alloc", acc_ptr, 0);
        chk("t1_busy", busy, 1);
      end
    end
    lat = 1;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk("t1_latency", lat, 9);
    chk("t1_ptr", res_ptr, 0);
    chk("t1_sum", res_sum, 4224);
    chk("t1_sq", res_sq, 32384);
    tick();
    chk("t1_pulse", res_valid, 0);
    free_bank(0);
    chk("t1_free_mask", busy, 0);

    // ---- five tokens back-to-back, no frees ----
    base = rq.size();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 12; k++) begin
        send(t + 1);
        if (k == 0) chk("t2_alloc", acc_ptr, t);
      end
    end
    chk("t2_full_mask", busy, 15);
    chk("t2_full_ready", s_ready, 0);
    s_data = fill(5);
    s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t2_stall_ready", s_ready, 0);
    end
    bank_free = 1'b1;
    bank_free_ptr = 2'd2;
    #1;
    chk("t2_ready_in_free_cycle", s_ready, 0);
    tick();
    bank_free = 1'b0;
    chk("t2_mask_after_free", busy, 11);
    for (int k = 0; k < 12; k++) begin
      send(5);
      if (k == 0) chk("t2_alloc5", acc_ptr, 2);
    end
    wait_res(base + 5);
    chk_res("t2_tok0", base + 0, 0, 768,  768);
    chk_res("t2_tok1", base + 1, 1, 1536, 3072);
    chk_res("t2_tok2", base + 2, 2, 2304, 6912);
    chk_res("t2_tok3", base + 3, 3, 3072, 12288);
    chk_res("t2_tok4", base + 4, 2, 3840, 19200);
    free_bank(0); free_bank(1); free_bank(3); free_bank(2);
    chk("t2_mask_clear", busy, 0);
    chk("t2_err", err, 0);

    // ---- gaps inside a token, lanes = -3 ----
    base = rq.size();
    for (int k = 0; k < 12; k++) begin
      gaps = (k % 3 == 1) ? 2 : int'($urandom_range(0, 2));
      if (k > 0) begin
        for (int g = 0; g < gaps; g++) begin
          tick();
          chk("t3_gap_acc_valid", acc_valid, 0);
        end
      end
      send(-3);
      chk("t3_cnt", acc_cnt, k);
    end
    wait_res(base + 1);
    chk_res("t3", base, 0, -2304, 6912);
    free_bank(0);

    // ---- error paths ----
    free_bank(1);
    chk("t4_free_err", err, 2);
    chk("t4_mask_unchanged", busy, 0);
    base = rq.size();
    inj = 1'b1;
    for (int k = 0; k < 12; k++) send(2);
    wait_res(base + 1);
    inj = 1'b0;
    chk("t4_seq_err", err, 3);
    chk_res("t4", base, 0, 1536, 3072);

    // ---- enable low mid-token (bank 0 still held) ----
    base = rq.size();
    for (int k = 0; k < 5; k++) begin
      send(k);
      if (k == 0) chk("t5_alloc", acc_ptr, 1);
    end
    en = 1'b0;
    s_data = fill(5);
    s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t5_stall_ready", s_ready, 0);
      chk("t5_stall_acc_valid", acc_valid, 0);
    end
    chk("t5_acc_en_low", acc_en, 0);
    en = 1'b1;
    for (int k = 5; k < 12; k++) begin
      send(k);
      chk("t5_cnt", acc_cnt, k);
    end
    wait_res(base + 1);
    chk_res("t5", base, 1, 4224, 32384);
    chk("t5_mask", busy, 3);

    // ---- reset pulse at beat 6 ----
    for (int k = 0; k < 6; k++) begin
      send(5);
      if (k == 0) chk("t6_alloc", acc_ptr, 2);
    end
    s_data = fill(6);
    s_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", s_ready, 0);
    chk("t6_rst_acc_en", acc_en, 0);
    chk("t6_rst_acc_valid", acc_valid, 0);
    chk("t6_rst_acc_ptr", acc_ptr, 0);
    chk("t6_rst_acc_cnt", acc_cnt, 0);
    chk("t6_rst_acc_data", longint'(acc_data != '0), 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_res_ptr", res_ptr, 0);
    chk("t6_rst_res_sum", res_sum, 0);
    chk("t6_rst_res_sq", res_sq, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    base = rq.size();
    for (int k = 0; k < 12; k++) begin
      send(k);
      if (k == 0) chk("t6_realloc", acc_ptr, 0);
    end
    wait_res(base + 1);
    chk_res("t6", base, 0, 4224, 32384);
    chk("t6_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
